// File: rtl/alu_iter_shift_unit.sv
// Integer ALU for the issue->writeback slot of the integer pipe.
// Add/sub/compare/logic finish in one cycle. Shifts iterate, moving up to
// SHIFT_STEP bit positions per cycle, so a wide barrel shifter is not needed.
//
// state  | meaning
// IDLE   | no operation held, ready to accept
// SHIFT  | iterating a shift, remaining count > 0
// RESULT | wb_valid high, result held until wb_ready
module alu_iter_shift_unit #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 8,
  parameter int ID_W       = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [3:0]      issue_op,
  input  logic [XLEN-1:0] issue_rs1,
  input  logic [XLEN-1:0] issue_rs2,
  input  logic [ID_W-1:0] issue_id,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [ID_W-1:0] wb_id,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  // SHIFT_STEP can equal XLEN, so it needs one bit more than a shift amount.
  localparam logic [SHW:0] STEP_MAX = (SHW+1)'(SHIFT_STEP);

  logic [1:0]      state;
  logic [XLEN-1:0] sh_reg;
  logic [SHW-1:0]  rem_cnt;
  logic            sh_left;
  logic            sh_fill;
  logic [ID_W-1:0] sh_id;

  logic            accept;
  logic            is_shift;
  logic [SHW-1:0]  shamt;
  logic            cmp_pad1;
  logic            cmp_pad2;
  logic            cmp_lt;
  logic [XLEN-1:0] alu_res;
  logic [SHW:0]    rem_ext;
  logic [SHW:0]    step_amt;
  logic [SHW-1:0]  rem_next;
  logic [XLEN-1:0] sh_next;

  assign issue_ready = (state == ST_IDLE) || ((state == ST_RESULT) && wb_ready);
  assign accept      = issue_valid && issue_ready;
  assign wb_valid    = (state == ST_RESULT);
  assign busy        = (state != ST_IDLE);
  assign is_shift    = (issue_op == OP_SLL) || (issue_op == OP_SRL) || (issue_op == OP_SRA);
  assign shamt       = issue_rs2[SHW-1:0];

  // Single-cycle result; shifts reach here only with a zero amount.
  always_comb begin
    cmp_pad1 = (issue_op == OP_SLT) ? issue_rs1[XLEN-1] : 1'b0;
    cmp_pad2 = (issue_op == OP_SLT) ? issue_rs2[XLEN-1] : 1'b0;
    // Sign of the XLEN+1 bit difference is the less-than flag.
    cmp_lt   = $signed({cmp_pad1, issue_rs1}) < $signed({cmp_pad2, issue_rs2});
    alu_res  = issue_rs1 + issue_rs2;
    case (issue_op)
      OP_SUB:                  alu_res = issue_rs1 - issue_rs2;
      OP_SLT, OP_SLTU:         alu_res = {{(XLEN-1){1'b0}}, cmp_lt};
      OP_XOR:                  alu_res = issue_rs1 ^ issue_rs2;
      OP_OR:                   alu_res = issue_rs1 | issue_rs2;
      OP_AND:                  alu_res = issue_rs1 & issue_rs2;
      OP_SLL, OP_SRL, OP_SRA:  alu_res = issue_rs1;
      default:                 alu_res = issue_rs1 + issue_rs2;
    endcase
  end

  // One shift iteration: step = min(SHIFT_STEP, remaining).
  always_comb begin
    rem_ext  = {1'b0, rem_cnt};
    step_amt = (rem_ext < STEP_MAX) ? rem_ext : STEP_MAX;
    rem_next = rem_cnt - step_amt[SHW-1:0];
    if (sh_left) begin
      sh_next = sh_reg << step_amt;
    end else begin
      sh_next = XLEN'($signed({sh_fill, sh_reg}) >>> step_amt);
    end
  end

  // Control FSM and result/tag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sh_reg  <= '0;
      rem_cnt <= '0;
      sh_left <= 1'b0;
      sh_fill <= 1'b0;
      sh_id   <= '0;
      wb_data <= '0;
      wb_id   <= '0;
    end else if (accept) begin
      if (is_shift && (shamt != '0)) begin
        state   <= ST_SHIFT;
        sh_reg  <= issue_rs1;
        rem_cnt <= shamt;
        sh_left <= (issue_op == OP_SLL);
        sh_fill <= (issue_op == OP_SRA) && issue_rs1[XLEN-1];
        sh_id   <= issue_id;
      end else begin
        state   <= ST_RESULT;
        wb_data <= alu_res;
        wb_id   <= issue_id;
      end
    end else if (state == ST_SHIFT) begin
      sh_reg  <= sh_next;
      rem_cnt <= rem_next;
      if (rem_next == '0) begin
        state   <= ST_RESULT;
        wb_data <= sh_next;
        wb_id   <= sh_id;
      end
    end else if ((state == ST_RESULT) && wb_ready) begin
      state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_alu_iter_shift_unit.sv
// Randomised and directed checks of alu_iter_shift_unit against an
// arithmetic reference model; a second 64-bit, step-1 instance covers the
// wide/slow configuration.
module tb_alu_iter_shift_unit;

  logic        clk;
  logic        rst;

  logic        issue_valid, issue_ready, wb_valid, wb_ready, busy;
  logic [3:0]  issue_op;
  logic [31:0] issue_rs1, issue_rs2, wb_data;
  logic [2:0]  issue_id, wb_id;

  logic        issue_valid_w, issue_ready_w, wb_valid_w, wb_ready_w, busy_w;
  logic [3:0]  issue_op_w;
  logic [63:0] issue_rs1_w, issue_rs2_w, wb_data_w;
  logic [2:0]  issue_id_w, wb_id_w;

  int n_checks = 0;
  int n_pass   = 0;

  alu_iter_shift_unit #(.XLEN(32), .SHIFT_STEP(8), .ID_W(3)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_id(issue_id),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_id(wb_id),
    .busy(busy)
  );

  alu_iter_shift_unit #(.XLEN(64), .SHIFT_STEP(1), .ID_W(3)) dut_w (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid_w), .issue_ready(issue_ready_w), .issue_op(issue_op_w),
    .issue_rs1(issue_rs1_w), .issue_rs2(issue_rs2_w), .issue_id(issue_id_w),
    .wb_valid(wb_valid_w), .wb_ready(wb_ready_w), .wb_data(wb_data_w), .wb_id(wb_id_w),
    .busy(busy_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference result for a w-bit unit, from the instruction semantics.
  function automatic logic [63:0] ref_alu(input int w, input logic [3:0] op,
                                          input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] mask, a, b, r;
    longint sa, sb;
    int amt;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    a = a_in & mask;
    b = b_in & mask;
    sa = longint'(a << (64 - w)) >>> (64 - w);
    sb = longint'(b << (64 - w)) >>> (64 - w);
    amt = int'(b % w);
    case (op)
      4'd1: r = a - b;
      4'd2: r = (sa < sb) ? 64'd1 : 64'd0;
      4'd3: r = (a < b) ? 64'd1 : 64'd0;
      4'd4: r = a ^ b;
      4'd5: r = a | b;
      4'd6: r = a & b;
      4'd7: r = a << amt;
      4'd8: r = a >> amt;
      4'd9: r = 64'(sa >>> amt);
      default: r = a + b;
    endcase
    return r & mask;
  endfunction

  function automatic int ref_lat(input int w, input int step, input logic [3:0] op,
                                 input logic [63:0] b);
    int amt;
    amt = int'(b % w);
    if ((op == 4'd7 || op == 4'd8 || op == 4'd9) && amt != 0)
      return 1 + (amt + step - 1) / step;
    return 1;
  endfunction

  // One op on the 32-bit unit, with `hold` cycles of writeback backpressure.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] id, input int hold);
    logic [63:0] exp;
    int exp_lat, lat;
    exp = ref_alu(32, op, {32'd0, a}, {32'd0, b});
    exp_lat = ref_lat(32, 8, op, {32'd0, b});
    wb_ready = 1'b0;
    issue_op = op; issue_rs1 = a; issue_rs2 = b; issue_id = id; issue_valid = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    issue_op = 4'($urandom); issue_rs1 = $urandom; issue_rs2 = $urandom; issue_id = 3'($urandom);
    lat = 1;
    while (!wb_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("wb_data", {32'd0, wb_data}, exp);
    chk("wb_id", {61'd0, wb_id}, {61'd0, id});
    for (int i = 0; i < hold; i++) begin
      issue_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", {63'd0, wb_valid}, 64'd1);
      chk("hold_data", {32'd0, wb_data}, exp);
      chk("hold_id", {61'd0, wb_id}, {61'd0, id});
      chk("hold_issue_ready", {63'd0, issue_ready}, 64'd0);
    end
    issue_valid = 1'b0;
    wb_ready = 1'b1;
    @(posedge clk); #1;
    chk("retire_valid", {63'd0, wb_valid}, 64'd0);
    chk("retire_busy", {63'd0, busy}, 64'd0);
    wb_ready = 1'b0;
  endtask

  task automatic run_w(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] id);
    logic [63:0] exp;
    int exp_lat, lat;
    exp = ref_alu(64, op, a, b);
    exp_lat = ref_lat(64, 1, op, b);
    wb_ready_w = 1'b1;
    issue_op_w = op; issue_rs1_w = a; issue_rs2_w = b; issue_id_w = id; issue_valid_w = 1'b1;
    @(posedge clk); #1;
    issue_valid_w = 1'b0;
    issue_rs1_w = {$urandom, $urandom};
    lat = 1;
    while (!wb_valid_w && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w64_latency", 64'(lat), 64'(exp_lat));
    chk("w64_data", wb_data_w, exp);
    chk("w64_id", {61'd0, wb_id_w}, {61'd0, id});
    @(posedge clk); #1;
    chk("w64_retire", {63'd0, wb_valid_w}, 64'd0);
  endtask

  initial begin
    int seen;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    rst = 1'b1;
    issue_valid = 1'b0; issue_op = '0; issue_rs1 = '0; issue_rs2 = '0; issue_id = '0; wb_ready = 1'b0;
    issue_valid_w = 1'b0; issue_op_w = '0; issue_rs1_w = '0; issue_rs2_w = '0; issue_id_w = '0;
    wb_ready_w = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst_wb_data", {32'd0, wb_data}, 64'd0);
    chk("rst_wb_id", {61'd0, wb_id}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_issue_ready", {63'd0, issue_ready}, 64'd1);
    chk("rst_w64_busy", {63'd0, busy_w}, 64'd0);
    rst = 1'b0;

    run_op(4'd0, 32'h7FFF_FFFF, 32'h1, 3'd2, 0);
    run_op(4'd1, 32'h0, 32'h1, 3'd3, 0);
    run_op(4'd2, 32'hFFFF_FFFF, 32'h1, 3'd4, 0);
    run_op(4'd3, 32'hFFFF_FFFF, 32'h1, 3'd5, 0);
    run_op(4'd9, 32'h8000_0000, 32'd31, 3'd6, 0);
    run_op(4'd7, 32'h1, 32'h0, 3'd7, 0);
    run_op(4'd8, 32'hFFFF_FFFF, 32'd4, 3'd1, 3);
    run_op(4'd7, 32'h1, 32'h25, 3'd0, 1);
    run_op(4'd12, 32'h10, 32'h20, 3'd2, 0);

    // Back-to-back single-cycle ops at full throughput.
    wb_ready = 1'b1;
    issue_rs1 = 32'hF0F0_F0F0; issue_rs2 = 32'hFF00_FF00;
    issue_op = 4'd4; issue_id = 3'd1; issue_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b_xor_valid", {63'd0, wb_valid}, 64'd1);
    chk("b2b_xor", {32'd0, wb_data}, 64'h0FF0_0FF0);
    chk("b2b_ready", {63'd0, issue_ready}, 64'd1);
    issue_op = 4'd5; issue_id = 3'd2;
    @(posedge clk); #1;
    chk("b2b_or", {32'd0, wb_data}, 64'hFFF0_FFF0);
    chk("b2b_or_id", {61'd0, wb_id}, 64'd2);
    issue_op = 4'd6; issue_id = 3'd3;
    @(posedge clk); #1;
    chk("b2b_and", {32'd0, wb_data}, 64'hF000_F000);
    issue_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_done", {63'd0, wb_valid}, 64'd0);
    wb_ready = 1'b0;

    // Reset in the second SHIFT cycle of SLL by 20 discards the op.
    issue_op = 4'd7; issue_rs1 = 32'h3; issue_rs2 = 32'd20; issue_id = 3'd5; issue_valid = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    chk("shift_busy", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_valid", {63'd0, wb_valid}, 64'd0);
    chk("midrst_data", {32'd0, wb_data}, 64'd0);
    wb_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (wb_valid) seen++;
    end
    chk("midrst_no_wb", 64'(seen), 64'd0);
    wb_ready = 1'b0;

    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      run_op(rop, ra, rb, 3'($urandom), $urandom_range(0, 2));
    end

    run_w(4'd7, 64'h1, 64'd63, 3'd3);
    run_w(4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'h45, 3'd4);
    run_w(4'd9, 64'h8000_0000_0000_0000, 64'h7F, 3'd5);
    run_w(4'd2, 64'h8000_0000_0000_0000, 64'h1, 3'd6);
    for (int n = 0; n < 6; n++) begin
      run_w(4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_iter_shift_unit.md
Name: alu_iter_shift_unit

Overview:
- Parametrised successor to the single-cycle ALU datapath: integer ALU with valid/ready issue and writeback handshakes and an iterative multi-cycle barrel-shift path.
- Step size is set by SHIFT_STEP.
- Sits between issue and writeback in the integer pipe.
- Add/sub/compare/logic complete in one cycle. Shifts take one cycle per SHIFT_STEP bits of shift amount.

Parameters:
- XLEN, 32, datapath width; power of 2, 8..64.
- SHIFT_STEP, 8, max bits shifted per iteration; power of 2, 1..XLEN.
- ID_W, 3, width of the instruction tag carried through.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  operation offered.
- issue_ready  out  1  unit can accept this cycle.
- issue_op  in  4  0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA; 10-15 execute as ADD.
- issue_rs1  in  XLEN  operand 1.
- issue_rs2  in  XLEN  operand 2; shift amount = issue_rs2[log2(XLEN)-1:0].
- issue_id  in  ID_W  tag.
- wb_valid  out  1  result available.
- wb_ready  in  1  consumer takes result.
- wb_data  out  XLEN  result.
- wb_id  out  ID_W  tag of result.
- busy  out  1  state != IDLE.

Behaviour:
- Accept event: issue_valid && issue_ready at a rising edge.
- issue_ready = (state==IDLE) || (state==RESULT && wb_ready). This allows back-to-back single-cycle ops at full throughput.
- Reset: state IDLE; wb_valid 0, wb_data 0, wb_id 0, busy 0; internal remaining-count and shift register 0. Reset during SHIFT or RESULT discards the op and produces no writeback.
- FSM states: IDLE, SHIFT, RESULT.
- IDLE + accept, non-shift op or shift with amount 0 -> RESULT. wb_data is computed combinationally from the inputs and registered.
- IDLE + accept, shift with amount > 0 -> SHIFT. Latch the operand into the shift register, remaining = amount, direction/arith flag, tag.
- SHIFT, each cycle:
  - step = min(SHIFT_STEP, remaining); shift by step; remaining -= step.
  - If the new remaining is 0 -> RESULT and load wb_data.
  - SRA fills with the latched rs1[XLEN-1]. SRL and SLL fill with 0.
- RESULT: wb_valid=1. wb_data and wb_id are held stable until wb_ready.
  - wb_ready && accept -> behaves as the IDLE+accept transition.
  - wb_ready && !accept -> IDLE.
  - !wb_ready -> stay.
- Latency, accept to wb_valid: 1 cycle for non-shift ops; 1 + ceil(amount/SHIFT_STEP) cycles for shifts.
- Arithmetic:
  - ADD/SUB are modulo 2^XLEN.
  - SLT/SLTU use an XLEN+1-bit subtraction. Pad bit is the operand sign for SLT and 0 for SLTU. Result = borrow/sign bit, zero-extended to XLEN.
  - Logic ops are bitwise.
- Only bits [log2(XLEN)-1:0] of rs2 form the shift amount; upper bits are ignored (rs2=0x25 with XLEN=32 shifts by 5).
- issue_* inputs are sampled only on accept. Changes at other times have no effect.
- wb_ready asserted while wb_valid=0 has no effect.

Test Plan:
- ADD 0x7FFFFFFF+1, id 2, wb_ready=1 -> wb_valid next cycle, wb_data 0x80000000, wb_id 2. SUB 0-1 -> 0xFFFFFFFF.
- SLT rs1=0xFFFFFFFF, rs2=1 -> 1. SLTU same operands -> 0. Back-to-back XOR/OR/AND 0xF0F0F0F0 with 0xFF00FF00, wb_ready=1 -> three results on consecutive cycles: 0x0FF00FF0, 0xFFF0FFF0, 0xF000F000.
- SRA 0x80000000 by 31 (SHIFT_STEP=8) -> busy 4 cycles in SHIFT, wb_valid at accept+5, wb_data 0xFFFFFFFF. SLL 1 by 0 -> 1-cycle latency, result 1.
- Backpressure: SRL 0xFFFFFFFF by 4, wb_ready=0 for 3 cycles -> wb_valid, wb_data 0x0FFFFFFF and wb_id stable; issue_ready=0; a new op offered is not accepted until wb_ready=1.
- Assert rst in the 2nd SHIFT cycle of SLL by 20 -> next cycle state IDLE, wb_valid 0, busy 0; no result ever appears for that id.
- Parameter sweep XLEN=64, SHIFT_STEP=1: SLL 1 by 63 -> latency 64, result 0x8000000000000000. rs2=0x45 shifts by 5.
